// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter for a single shared data-memory port.
// Each requester has a one-deep pending slot. At most one memory transaction is in flight at a time.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CACHE_LINE_SIZE = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       s0_strobe_i,
  input  logic [ADDR_WIDTH-1:0]      s0_addr_i,
  input  logic                       s0_rw_i,
  input  logic [CACHE_LINE_SIZE-1:0] s0_data_i,
  output logic                       s0_done_o,
  output logic [CACHE_LINE_SIZE-1:0] s0_data_o,
  input  logic                       s1_strobe_i,
  input  logic [ADDR_WIDTH-1:0]      s1_addr_i,
  input  logic                       s1_rw_i,
  input  logic [CACHE_LINE_SIZE-1:0] s1_data_i,
  output logic                       s1_done_o,
  output logic [CACHE_LINE_SIZE-1:0] s1_data_o,
  output logic                       M_DMEM_strobe,
  output logic [ADDR_WIDTH-1:0]      M_DMEM_addr,
  output logic                       M_DMEM_rw,
  output logic [CACHE_LINE_SIZE-1:0] M_DMEM_dataout,
  input  logic                       M_DMEM_done,
  input  logic [CACHE_LINE_SIZE-1:0] M_DMEM_datain,
  output logic                       busy_o,
  output logic [1:0]                 overrun_o
);
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = CACHE_LINE_SIZE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    valid_q, valid_d;
  logic [AW-1:0] p_addr_q [2];
  logic [AW-1:0] p_addr_d [2];
  logic [1:0]    p_rw_q, p_rw_d;
  logic [DW-1:0] p_data_q [2];
  logic [DW-1:0] p_data_d [2];
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [1:0]    overrun_q, overrun_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q [2];
  logic [DW-1:0] rdata_d [2];
  logic          m_strobe_q, m_strobe_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic          m_rw_q, m_rw_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          busy_q, busy_d;

  logic [1:0]    req_strobe;
  logic [1:0]    req_rw;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_data [2];
  logic [1:0]    retire;
  logic          sel;

  assign req_strobe  = {s1_strobe_i, s0_strobe_i};
  assign req_rw      = {s1_rw_i, s0_rw_i};
  assign req_addr[0] = s0_addr_i;
  assign req_addr[1] = s1_addr_i;
  assign req_data[0] = s0_data_i;
  assign req_data[1] = s1_data_i;

  // Next-state: arbitration FSM, pending-slot load/retire, completion capture
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    p_addr_d   = p_addr_q;
    p_rw_d     = p_rw_q;
    p_data_d   = p_data_q;
    grant_d    = grant_q;
    last_d     = last_q;
    overrun_d  = overrun_q;
    rdata_d    = rdata_q;
    m_addr_d   = m_addr_q;
    m_rw_d     = m_rw_q;
    m_data_d   = m_data_q;
    done_d     = 2'b00;
    m_strobe_d = 1'b0;
    retire     = 2'b00;
    sel        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_q != 2'b00) begin
          // Contention goes to whoever was not granted last.
          sel        = (valid_q == 2'b11) ? ~last_q : valid_q[1];
          grant_d    = sel;
          m_strobe_d = 1'b1;
          m_addr_d   = p_addr_q[sel];
          m_rw_d     = p_rw_q[sel];
          m_data_d   = p_data_q[sel];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (M_DMEM_done) begin
          retire[grant_q]  = 1'b1;
          done_d[grant_q]  = 1'b1;
          rdata_d[grant_q] = M_DMEM_datain;
          last_d           = grant_q;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < 2; i++) begin
      if (retire[i]) valid_d[i] = 1'b0;
      if (req_strobe[i]) begin
        if (!valid_q[i] || retire[i]) begin
          valid_d[i]  = 1'b1;
          p_addr_d[i] = req_addr[i];
          p_rw_d[i]   = req_rw[i];
          p_data_d[i] = req_data[i];
        end else begin
          overrun_d[i] = 1'b1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= 2'b00;
      p_rw_q     <= 2'b00;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      overrun_q  <= 2'b00;
      done_q     <= 2'b00;
      m_strobe_q <= 1'b0;
      m_addr_q   <= '0;
      m_rw_q     <= 1'b0;
      m_data_q   <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        p_addr_q[i] <= '0;
        p_data_q[i] <= '0;
        rdata_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      p_addr_q   <= p_addr_d;
      p_rw_q     <= p_rw_d;
      p_data_q   <= p_data_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      m_strobe_q <= m_strobe_d;
      m_addr_q   <= m_addr_d;
      m_rw_q     <= m_rw_d;
      m_data_q   <= m_data_d;
      busy_q     <= busy_d;
    end
  end

  assign s0_done_o      = done_q[0];
  assign s1_done_o      = done_q[1];
  assign s0_data_o      = rdata_q[0];
  assign s1_data_o      = rdata_q[1];
  assign M_DMEM_strobe  = m_strobe_q;
  assign M_DMEM_addr    = m_addr_q;
  assign M_DMEM_rw      = m_rw_q;
  assign M_DMEM_dataout = m_data_q;
  assign busy_o         = busy_q;
  assign overrun_o      = overrun_q;

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter CACHE_LINE_SIZE, default 256, data bus width in bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset; no other clock or reset inputs.
REQ-004 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 s0_strobe_i  input  1  requester 0 (allocator master) one-cycle request pulse.
REQ-007 s0_addr_i / s0_rw_i / s0_data_i  input  ADDR_WIDTH / 1 / CACHE_LINE_SIZE  request address, 1=write 0=read, write data.
REQ-008 s0_done_o / s0_data_o  output  1 / CACHE_LINE_SIZE  completion pulse, read data.
REQ-009 s1_strobe_i, s1_addr_i, s1_rw_i, s1_data_i, s1_done_o, s1_data_o  same widths as REQ-006..008  requester 1 (atomic unit).
REQ-010 M_DMEM_strobe / M_DMEM_addr / M_DMEM_rw / M_DMEM_dataout  output  1 / ADDR_WIDTH / 1 / CACHE_LINE_SIZE  shared memory port request.
REQ-011 M_DMEM_done / M_DMEM_datain  input  1 / CACHE_LINE_SIZE  memory completion pulse, read data.
REQ-012 busy_o  output  1  high whenever FSM is not IDLE.
REQ-013 overrun_o  output  2  sticky per-requester flag: strobe arrived while that requester already pending.

Function
REQ-014 Each requester SHALL have a pending register (valid, addr, rw, data) loaded at the edge ending a cycle in which sN_strobe_i=1 and its valid=0.
REQ-015 Strobe while valid=1 SHALL be dropped and SHALL set overrun_o[N]; flag is cleared only by reset.
REQ-016 Strobe in the same cycle the requester's pending entry is retired (REQ-021) SHALL be accepted; set wins over clear.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT; reset state IDLE.
REQ-018 IDLE: if any valid, select requester, record grant, go ISSUE; else stay.
REQ-019 Selection SHALL be round-robin: with both valid, grant the requester not granted last; last-grant resets to 1 so requester 0 wins first contention.
REQ-020 ISSUE: M_DMEM_strobe=1 for exactly this one cycle; M_DMEM_addr/rw/dataout driven from granted pending entry, held stable through WAIT; next state WAIT.
REQ-021 WAIT: on M_DMEM_done=1, clear granted valid, update last-grant, go IDLE; otherwise stay with no timeout.
REQ-022 sN_done_o SHALL pulse one cycle, in the cycle after M_DMEM_done, for the granted requester only; never both in one cycle.
REQ-023 sN_data_o SHALL register M_DMEM_datain on the M_DMEM_done edge for the granted requester (reads and writes alike) and hold until that requester's next completion.
REQ-024 M_DMEM_done in IDLE or ISSUE SHALL be ignored.
REQ-025 Minimum latency: strobe in cycle t -> M_DMEM_strobe in t+2; M_DMEM_done in cycle d -> sN_done_o in d+1; next grant's M_DMEM_strobe no earlier than d+2.
REQ-026 At most one memory transaction outstanding; the arbiter SHALL NOT reorder requests from a single requester.

Reset
REQ-027 With rst_i=1 at an edge: state IDLE, both valid=0, last-grant=1, overrun_o=0, busy_o=0, M_DMEM_strobe=0, M_DMEM_addr/rw/dataout=0, sN_done_o=0, sN_data_o=0.
REQ-028 Reset mid-transaction SHALL abandon it; a subsequent stale M_DMEM_done SHALL produce no sN_done_o.
REQ-029 Strobes sampled in a cycle with rst_i=1 SHALL be discarded.

Verification
REQ-030 Single read: s0 strobe t=0, addr 0x90000040, rw=0; memory done at t=5 with data 0xA5..A5 -> M_DMEM_strobe at t=2 only, addr 0x90000040; s0_done_o at t=6; s0_data_o=0xA5..A5.
REQ-031 Simultaneous strobes s0 (write 0x90000000) and s1 (read 0x90000020) at t=0 -> s0 served first, s1's M_DMEM_strobe at least 2 cycles after s0's done edge; s1 served second; no overrun.
REQ-032 Fairness: both requesters strobe again immediately on each done for 6 transactions -> grants strictly alternate 0,1,0,1,0,1.
REQ-033 Overrun: s1 strobes twice while pending -> overrun_o=2'b10, one memory transaction only, first address used.
REQ-034 Reset asserted one cycle in WAIT, memory done arrives 2 cycles later -> all outputs at reset values, no done pulse, busy_o=0.
REQ-035 Back-to-back: s0 strobes in the same cycle as s0_done_o -> new request accepted and issued, no overrun.
